// File: rtl/teng_phy_pkg.sv
// ---------------------------------------------------------------------------
// teng_phy_pkg
//   Constants and types shared by the 10GBASE-R transmit datapath.
//   - 64b/66b sync header encodings.
//   - Clause 49 scrambler taps and state width (G(x) = 1 + x^39 + x^58).
//   - PRBS31 test-pattern polynomial (x^31 + x^28 + 1), seed and step size.
//   - Output source selector used by the scrambler stage.
// ---------------------------------------------------------------------------
package teng_phy_pkg;

   localparam logic [1:0] SYNC_CTRL = 2'b01;
   localparam logic [1:0] SYNC_DATA = 2'b10;

   localparam int BLK_DATA_W  = 64;
   localparam int SCR_TAP_A   = 39;
   localparam int SCR_TAP_B   = 58;
   localparam int SCR_STATE_W = 58;

   localparam int              PRBS_W     = 31;
   localparam int              PRBS_TAP_A = 31;
   localparam int              PRBS_TAP_B = 28;
   localparam int              PRBS_STEP  = 66;
   localparam logic [PRBS_W-1:0] PRBS_SEED = 31'h7FFF_FFFF;

   // Which source feeds the registered payload on a valid cycle.
   typedef enum logic [1:0] {
      SRC_SCR  = 2'd0,
      SRC_BYP  = 2'd1,
      SRC_PRBS = 2'd2
   } scr_src_t;

endpackage

// File: rtl/teng_prbs31_gen66.sv
// ---------------------------------------------------------------------------
// teng_prbs31_gen66
//   PRBS31 (x^31 + x^28 + 1) pattern generator producing 66 bits per enabled
//   clock. prbs_o presents the 66 bits of the current step combinationally;
//   the generator state advances by 66 bits on each cycle with en_i=1.
//   prbs_o[0] is the first bit of the step in transmission order.
//
// Ports:
//   clk_i   in   1   block clock
//   rst_i   in   1   asynchronous active-low reset (state <= PRBS_SEED)
//   en_i    in   1   advance the generator by one 66-bit step
//   prbs_o  out  66  pattern bits of the current step
// ---------------------------------------------------------------------------
module teng_prbs31_gen66
   import teng_phy_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   output logic [PRBS_STEP-1:0] prbs_o
);

   logic [PRBS_W-1:0]    r_state;
   logic [PRBS_W-1:0]    w_state_nxt;
   logic [PRBS_STEP-1:0] w_bits;

   // Serial LFSR unrolled 66 times; each new bit is the feedback of the
   // bits 31 and 28 positions back, shifted in at the low end.
   always_comb begin
      w_state_nxt = r_state;
      w_bits      = '0;
      for (int i = 0; i < PRBS_STEP; i++) begin
         w_bits[i]   = w_state_nxt[PRBS_TAP_A-1] ^ w_state_nxt[PRBS_TAP_B-1];
         w_state_nxt = {w_state_nxt[PRBS_W-2:0], w_bits[i]};
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= PRBS_SEED;
      end else if (en_i) begin
         r_state <= w_state_nxt;
      end
   end

   assign prbs_o = w_bits;

endmodule

// File: rtl/teng_tx_scrambler.sv
// ---------------------------------------------------------------------------
// teng_tx_scrambler
//   10GBASE-R transmit scrambler stage, downstream of the 64b/66b encoder.
//   Scrambles the 64-bit payload with the Clause 49 self-synchronous
//   scrambler G(x) = 1 + x^39 + x^58, passes the sync header through
//   unscrambled and aligned with its payload (1 clk latency), and keeps a
//   saturating count of encoder-reported errors.
//
//   Optional build macro TX_PRBS31_EN: adds a PRBS31 test-pattern generator
//   that replaces header and payload while test_mode_i=1. Without the macro
//   test_mode_i is ignored and no generator is built.
//
// Ports:
//   clk_i              in   1          TX block clock
//   rst_i              in   1          asynchronous active-low reset
//   encode_data_i      in   64         payload, bit 0 transmitted first
//   encode_head_i      in   2          sync header (01 control, 10 data)
//   encode_data_vld_i  in   1          payload/header qualifier
//   encode_error_i     in   1          encoder error, counted on valid cycles
//   bypass_i           in   1          1 = pass payload unscrambled
//   test_mode_i        in   1          1 = PRBS31 output (TX_PRBS31_EN only)
//   err_cnt_clr_i      in   1          synchronous clear of err_cnt_o
//   scr_data_o         out  64         scrambled payload
//   scr_head_o         out  2          delayed sync header
//   scr_data_vld_o     out  1          output qualifier
//   err_cnt_o          out  ERR_CNT_W  saturating encode-error count
// ---------------------------------------------------------------------------
module teng_tx_scrambler
   import teng_phy_pkg::*;
#(
   parameter logic [57:0] SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF,
   parameter int          ERR_CNT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [63:0]          encode_data_i,
   input  logic [1:0]           encode_head_i,
   input  logic                 encode_data_vld_i,
   input  logic                 encode_error_i,
   input  logic                 bypass_i,
   input  logic                 test_mode_i,
   input  logic                 err_cnt_clr_i,
   output logic [63:0]          scr_data_o,
   output logic [1:0]           scr_head_o,
   output logic                 scr_data_vld_o,
   output logic [ERR_CNT_W-1:0] err_cnt_o
);

   localparam int DATA_W = BLK_DATA_W;
   localparam int EXT_W  = SCR_STATE_W + DATA_W;

   // Fully unrolled scrambler. The working vector holds the 58 previous
   // scrambled bits below the 64 new ones, so s[n-39] and s[n-58] are plain
   // look-backs whether they land in the old state or in this block.
   function automatic logic [DATA_W-1:0] scr_block(input logic [DATA_W-1:0]      d,
                                                   input logic [SCR_STATE_W-1:0] st);
      logic [EXT_W-1:0] x;
      x = {{DATA_W{1'b0}}, st};
      for (int n = 0; n < DATA_W; n++) begin
         x[SCR_STATE_W+n] = d[n] ^ x[SCR_STATE_W+n-SCR_TAP_A]
                                 ^ x[SCR_STATE_W+n-SCR_TAP_B];
      end
      return x[EXT_W-1:SCR_STATE_W];
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
      logic [ERR_CNT_W-1:0] one;
      one = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      return (&c) ? c : c + one;
   endfunction

   logic [SCR_STATE_W-1:0] r_scr_state;
   logic [DATA_W-1:0]      r_data_p1;
   logic [1:0]             r_head_p1;
   logic                   r_vld_p1;
   logic [ERR_CNT_W-1:0]   r_err_cnt;

   logic [DATA_W-1:0]      w_scr_data;
   logic [SCR_STATE_W-1:0] w_scr_state;
   logic [PRBS_STEP-1:0]   w_prbs;
   logic                   w_test_active;
   scr_src_t               w_src;
   logic [DATA_W-1:0]      w_data_nxt;
   logic [1:0]             w_head_nxt;
   logic [SCR_STATE_W-1:0] w_state_nxt;

   assign w_scr_data  = scr_block(encode_data_i, r_scr_state);
   // The newest scrambled bit s[63] lands in state[57].
   assign w_scr_state = w_scr_data[DATA_W-1:DATA_W-SCR_STATE_W];

`ifdef TX_PRBS31_EN
   // Generator runs on every valid cycle so the pattern is continuous across
   // the whole test-mode window.
   teng_prbs31_gen66 u_prbs (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (encode_data_vld_i),
      .prbs_o (w_prbs)
   );
   assign w_test_active = test_mode_i;
`else
   logic w_unused_test_mode;
   assign w_unused_test_mode = test_mode_i;
   assign w_prbs             = '0;
   assign w_test_active      = 1'b0;
`endif

   // Test mode outranks bypass; both freeze the scrambler state.
   always_comb begin
      w_src = SRC_SCR;
      if (w_test_active) begin
         w_src = SRC_PRBS;
      end else if (bypass_i) begin
         w_src = SRC_BYP;
      end
   end

   always_comb begin
      w_data_nxt  = w_scr_data;
      w_head_nxt  = encode_head_i;
      w_state_nxt = w_scr_state;
      case (w_src)
         SRC_BYP: begin
            w_data_nxt  = encode_data_i;
            w_state_nxt = r_scr_state;
         end
         SRC_PRBS: begin
            w_data_nxt  = w_prbs[PRBS_STEP-1:2];
            w_head_nxt  = w_prbs[1:0];
            w_state_nxt = r_scr_state;
         end
         default: begin
         end
      endcase
   end

   // ---- stage p0 -> p1: registered payload, header, qualifier, state ----
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_data_p1   <= '0;
         r_head_p1   <= 2'b00;
         r_vld_p1    <= 1'b0;
         r_scr_state <= SCR_SEED;
      end else begin
         r_vld_p1 <= encode_data_vld_i;
         if (encode_data_vld_i) begin
            r_data_p1   <= w_data_nxt;
            r_head_p1   <= w_head_nxt;
            r_scr_state <= w_state_nxt;
         end
      end
   end

   // Clear wins over a same-cycle increment.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_err_cnt <= '0;
      end else if (err_cnt_clr_i) begin
         r_err_cnt <= '0;
      end else if (encode_data_vld_i && encode_error_i) begin
         r_err_cnt <= sat_inc(r_err_cnt);
      end
   end

   assign scr_data_o     = r_data_p1;
   assign scr_head_o     = r_head_p1;
   assign scr_data_vld_o = r_vld_p1;
   assign err_cnt_o      = r_err_cnt;

endmodule

// File: tb/tb_teng_tx_scrambler.sv
// Testbench for teng_tx_scrambler: a default-seed instance and a zero-seed
// instance share all inputs. Directed table vectors, then hand-written
// sequences for random traffic, counter saturation, async reset and PRBS31.
module tb_teng_tx_scrambler;
   import teng_phy_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [63:0] encode_data_i;
   logic [1:0]  encode_head_i;
   logic        encode_data_vld_i;
   logic        encode_error_i;
   logic        bypass_i;
   logic        test_mode_i;
   logic        err_cnt_clr_i;

   logic [63:0] scr_data_o,     z_data_o;
   logic [1:0]  scr_head_o,     z_head_o;
   logic        scr_data_vld_o, z_vld_o;
   logic [15:0] err_cnt_o,      z_cnt_o;

   always #5 clk_i = ~clk_i;

   teng_tx_scrambler u_dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .encode_data_i(encode_data_i), .encode_head_i(encode_head_i),
      .encode_data_vld_i(encode_data_vld_i), .encode_error_i(encode_error_i),
      .bypass_i(bypass_i), .test_mode_i(test_mode_i), .err_cnt_clr_i(err_cnt_clr_i),
      .scr_data_o(scr_data_o), .scr_head_o(scr_head_o),
      .scr_data_vld_o(scr_data_vld_o), .err_cnt_o(err_cnt_o)
   );

   teng_tx_scrambler #(.SCR_SEED(58'h0)) u_dut0 (
      .clk_i(clk_i), .rst_i(rst_i),
      .encode_data_i(encode_data_i), .encode_head_i(encode_head_i),
      .encode_data_vld_i(encode_data_vld_i), .encode_error_i(encode_error_i),
      .bypass_i(bypass_i), .test_mode_i(test_mode_i), .err_cnt_clr_i(err_cnt_clr_i),
      .scr_data_o(z_data_o), .scr_head_o(z_head_o),
      .scr_data_vld_o(z_vld_o), .err_cnt_o(z_cnt_o)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Serial reference scrambler: q[57] is the newest scrambled bit.
   task automatic ref_scr(input logic [63:0] d, inout logic [57:0] q, output logic [63:0] s);
      logic b;
      s = '0;
      for (int n = 0; n < 64; n++) begin
         b    = d[n] ^ q[19] ^ q[0];
         s[n] = b;
         q    = {b, q[57:1]};
      end
   endtask

   // Serial reference descrambler, self-synchronising from any start state.
   task automatic ref_descr(input logic [63:0] s, inout logic [57:0] q, output logic [63:0] d);
      d = '0;
      for (int n = 0; n < 64; n++) begin
         d[n] = s[n] ^ q[19] ^ q[0];
         q    = {s[n], q[57:1]};
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] h, input logic [63:0] d,
                        input logic b, input logic e);
      encode_data_vld_i = v;
      encode_head_i     = h;
      encode_data_i     = d;
      bypass_i          = b;
      encode_error_i    = e;
   endtask

   typedef struct packed {
      logic        vld;
      logic [1:0]  head;
      logic [63:0] data;
      logic        byp;
      logic        err;
      logic        hm;     // 1: exp_m is a hand value for the default-seed DUT
      logic [63:0] exp_m;
      logic        h0;     // 1: exp_0 is a hand value for the zero-seed DUT
      logic [63:0] exp_0;
      logic [1:0]  exp_head;
      logic        exp_vld;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t tbl [10];

   logic [57:0] mq, mq0, dq;
   logic [63:0] em, e0, tmp, rec, d;
   logic [1:0]  h;
   logic        v, first;

   initial begin
      tbl[0] = '{1'b1, 2'b10, 64'h0, 1'b0, 1'b0, 1'b1, 64'h03FF_FF80_0000_0000, 1'b1, 64'h0, 2'b10, 1'b1, 16'd0};
      tbl[1] = '{1'b1, 2'b10, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0, 2'b10, 1'b1, 16'd0};
      tbl[2] = '{1'b0, 2'b01, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h0, 2'b10, 1'b0, 16'd0};
      tbl[3] = '{1'b1, 2'b10, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h0, 2'b10, 1'b1, 16'd1};
      tbl[4] = '{1'b1, 2'b10, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h0, 2'b10, 1'b1, 16'd2};
      tbl[5] = '{1'b1, 2'b01, 64'h1E, 1'b1, 1'b0, 1'b1, 64'h1E, 1'b1, 64'h1E, 2'b01, 1'b1, 16'd2};
      tbl[6] = '{1'b1, 2'b10, 64'h0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h0, 2'b10, 1'b1, 16'd3};
      tbl[7] = '{1'b1, 2'b01, 64'h1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 64'h0400_0080_0000_0001, 2'b01, 1'b1, 16'd3};
      tbl[8] = '{1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 64'h0400_0080_0000_0001, 2'b01, 1'b0, 16'd3};
      tbl[9] = '{1'b1, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 2'b10, 1'b1, 16'd3};

      // Reset state
      rst_i = 1'b0;
      drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
      test_mode_i   = 1'b0;
      err_cnt_clr_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_data",  scr_data_o, 64'h0);
      chk("rst_head",  64'(scr_head_o), 64'h0);
      chk("rst_vld",   64'(scr_data_vld_o), 64'h0);
      chk("rst_cnt",   64'(err_cnt_o), 64'h0);
      chk("rst_data0", z_data_o, 64'h0);
      rst_i = 1'b1;
      mq  = 58'h3FF_FFFF_FFFF_FFFF;
      mq0 = 58'h0;
      em  = '0;
      e0  = '0;

      // Table vectors, first valid block in the first clk after release
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].vld, tbl[i].head, tbl[i].data, tbl[i].byp, tbl[i].err);
         if (tbl[i].vld) begin
            if (tbl[i].byp) begin
               em = tbl[i].data;
               e0 = tbl[i].data;
            end else begin
               ref_scr(tbl[i].data, mq, em);
               ref_scr(tbl[i].data, mq0, e0);
            end
         end
         @(posedge clk_i);
         #1;
         chk($sformatf("tbl%0d_data", i),  scr_data_o, tbl[i].hm ? tbl[i].exp_m : em);
         chk($sformatf("tbl%0d_data0", i), z_data_o,   tbl[i].h0 ? tbl[i].exp_0 : e0);
         chk($sformatf("tbl%0d_head", i),  64'(scr_head_o), 64'(tbl[i].exp_head));
         chk($sformatf("tbl%0d_vld", i),   64'(scr_data_vld_o), 64'(tbl[i].exp_vld));
         chk($sformatf("tbl%0d_cnt", i),   64'(err_cnt_o), 64'(tbl[i].exp_cnt));
      end

      // Random traffic with gaps, recovered by a reference descrambler
      drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
      @(posedge clk_i);
      #1;
      dq    = '0;
      first = 1'b1;
      for (int i = 0; i < 200; i++) begin
         v = ($urandom_range(0, 3) != 0);
         d = {$urandom, $urandom};
         h = ($urandom_range(0, 1) == 1) ? SYNC_DATA : SYNC_CTRL;
         drive(v, h, d, 1'b0, 1'b0);
         @(posedge clk_i);
         #1;
         chk("rnd_vld", 64'(scr_data_vld_o), 64'(v));
         if (v) begin
            chk("rnd_head", 64'(scr_head_o), 64'(h));
            ref_descr(scr_data_o, dq, rec);
            if (!first) chk("rnd_descr", rec, d);
            first = 1'b0;
         end
      end

      // Error counter: clear, saturation, clear beats increment
      drive(1'b0, 2'b00, 64'h0, 1'b0, 1'b0);
      err_cnt_clr_i = 1'b1;
      @(posedge clk_i);
      #1;
      err_cnt_clr_i = 1'b0;
      chk("cnt_clr", 64'(err_cnt_o), 64'h0);
      drive(1'b1, 2'b10, 64'h5555_AAAA_5555_AAAA, 1'b0, 1'b1);
      for (int i = 0; i < 65534; i++) @(posedge clk_i);
      #1;
      chk("cnt_fffe", 64'(err_cnt_o), 64'hFFFE);
      @(posedge clk_i);
      #1;
      chk("cnt_ffff", 64'(err_cnt_o), 64'hFFFF);
      for (int i = 0; i < 4465; i++) @(posedge clk_i);
      #1;
      chk("cnt_sat", 64'(err_cnt_o), 64'hFFFF);
      err_cnt_clr_i = 1'b1;
      @(posedge clk_i);
      #1;
      err_cnt_clr_i = 1'b0;
      chk("cnt_clr_pri", 64'(err_cnt_o), 64'h0);
      @(posedge clk_i);
      #1;
      chk("cnt_after_clr", 64'(err_cnt_o), 64'h1);

      // Asynchronous reset mid-stream, then first block from the seed
      drive(1'b1, 2'b01, 64'hFEDC_BA98_7654_3210, 1'b0, 1'b0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      #1;
      chk("arst_data", scr_data_o, 64'h0);
      chk("arst_head", 64'(scr_head_o), 64'h0);
      chk("arst_vld",  64'(scr_data_vld_o), 64'h0);
      chk("arst_cnt",  64'(err_cnt_o), 64'h0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      mq  = 58'h3FF_FFFF_FFFF_FFFF;
      mq0 = 58'h0;
      d   = 64'hA5A5_0F0F_3C3C_9696;
      drive(1'b1, 2'b10, d, 1'b0, 1'b0);
      ref_scr(d, mq, em);
      ref_scr(d, mq0, e0);
      @(posedge clk_i);
      #1;
      chk("post_rst_data",  scr_data_o, em);
      chk("post_rst_data0", z_data_o, e0);

`ifdef TX_PRBS31_EN
      begin
         logic        hist [0:6599];
         logic [65:0] blk;
         int          nb, perr, ones;
         nb = 0; perr = 0; ones = 0;
         test_mode_i = 1'b1;
         for (int c = 0; c < 100; c++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), 1'b0);
            @(posedge clk_i);
            #1;
            blk = {scr_data_o, scr_head_o};
            for (int k = 0; k < 66; k++) begin
               hist[nb] = blk[k];
               if (blk[k]) ones++;
               if (nb >= 31 && (hist[nb] !== (hist[nb-31] ^ hist[nb-28]))) perr++;
               nb++;
            end
         end
         chk("prbs_errors", 64'(perr), 64'h0);
         chk("prbs_ones_present", 64'(ones > 2000), 64'h1);
         test_mode_i = 1'b0;
         d = 64'h1357_9BDF_0246_8ACE;
         drive(1'b1, 2'b10, d, 1'b0, 1'b0);
         ref_scr(d, mq, em);
         @(posedge clk_i);
         #1;
         chk("prbs_resume", scr_data_o, em);
      end
`else
      // test_mode_i has no effect without the generator
      test_mode_i = 1'b1;
      d = 64'h1357_9BDF_0246_8ACE;
      drive(1'b1, 2'b01, d, 1'b0, 1'b0);
      ref_scr(d, mq, em);
      @(posedge clk_i);
      #1;
      chk("tm_ignored_data", scr_data_o, em);
      chk("tm_ignored_head", 64'(scr_head_o), 64'(2'b01));
      test_mode_i = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/teng_tx_scrambler.md
Name: teng_tx_scrambler

Overview:
- Transmit-path stage directly downstream of the 64b/66b encoder; upstream of the GTX TX interface.
- Applies the IEEE 802.3 Clause 49 self-synchronous scrambler G(x)=1+x^39+x^58 to the 64-bit block payload.
- Passes the 2-bit sync header through unscrambled and time-aligned with its payload.
- Counts encoder-reported errors; optionally replaces traffic with a PRBS31 test pattern.

Parameters:
- SCR_SEED, 58'h3FF_FFFF_FFFF_FFFF: scrambler state loaded at reset.
- ERR_CNT_W, 16: width of the saturating encode-error counter.

Ports:
- clk_i  in  1  TX block clock, 312.5 MHz, same clock as the encoder.
- rst_i  in  1  asynchronous, active-low reset.
- encode_data_i  in  64  encoder payload; bit 0 is transmitted first.
- encode_head_i  in  2  sync header, 2'b01 = control, 2'b10 = data.
- encode_data_vld_i  in  1  payload/header qualifier.
- encode_error_i  in  1  encoder error flag, sampled only when valid.
- bypass_i  in  1  1 = pass payload unscrambled.
- test_mode_i  in  1  1 = PRBS31 output (only with TX_PRBS31_EN).
- err_cnt_clr_i  in  1  synchronous clear of err_cnt_o.
- scr_data_o  out  64  scrambled payload.
- scr_head_o  out  2  delayed sync header.
- scr_data_vld_o  out  1  output qualifier.
- err_cnt_o  out  ERR_CNT_W  saturating count of valid cycles with encode_error_i=1.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - scr_data_o=0, scr_head_o=2'b00, scr_data_vld_o=0, err_cnt_o=0.
  - Scrambler state=SCR_SEED; PRBS state=31'h7FFF_FFFF.
- Latency: exactly 1 clk from input to output for data, head and vld.
- scr_data_vld_o is the registered encode_data_vld_i.
- Data, head and state registers load only on valid cycles; otherwise they hold.
- Scrambling, per valid cycle, bit n=0..63 in ascending order:
  - s[n] = d[n] ^ s[n-39] ^ s[n-58].
  - Negative indices come from the 58-bit state, where the state holds the last 58 scrambled bits and state[57] is the most recent.
  - Next state = {s[63:6]}, mapped so the newest bit sits in state[57].
  - Realised as a fully unrolled 64-bit combinational function plus one register stage.
- Header: scr_head_o <= encode_head_i on valid cycles. No check of the header value.
- Bypass:
  - bypass_i=1 on a valid cycle: scr_data_o <= encode_data_i and the state holds.
  - Scrambling resumes from the held state when bypass_i returns to 0.
  - bypass_i is sampled per valid cycle, so switching mid-frame is legal and has no glitch-protection.
- Error counter:
  - Increments on each valid cycle with encode_error_i=1.
  - Saturates at all-ones.
  - err_cnt_clr_i has priority over increment in the same cycle; the result is 0.
- A valid cycle arriving in the first clk after reset release is processed normally.
- Reset mid-stream: state returns to SCR_SEED. The far-end descrambler self-resynchronises after 58 bits, so no additional handling is required.

Optional Feature:
- TX_PRBS31_EN defined:
  - A PRBS31 generator (x^31+x^28+1, Clause 49.2.8 style) advances 66 bits per valid cycle.
  - When test_mode_i=1, it replaces the output: scr_head_o = prbs[1:0], scr_data_o = prbs[65:2].
  - The scrambler state holds while in test mode.
  - test_mode_i has priority over bypass_i.
  - Latency is unchanged at 1 clk.
- TX_PRBS31_EN not defined: test_mode_i is present but ignored, and no generator logic is instantiated.

Decomposition:
- Shared package teng_phy_pkg holds:
  - SYNC_CTRL=2'b01 and SYNC_DATA=2'b10.
  - SCR_TAP_A=39, SCR_TAP_B=58, SCR_STATE_W=58.
  - PRBS31 taps (31, 28) and seed.
- One sub-module, teng_prbs31_gen66: 66-bit-per-step PRBS31 generator with enable, instantiated only under TX_PRBS31_EN.

Test Plan:
- SCR_SEED=0, encode_data_i=64'h0, head 2'b10, vld=1 for 4 cycles -> scr_data_o=64'h0 every cycle; head 2'b10 one clk later.
- Seed all-ones, random valid traffic with vld gaps -> a reference Clause 49 descrambler in the bench recovers input payloads exactly after the first 58 bits. Header sequence is identical; scr_data_vld_o equals vld delayed 1 clk.
- Idle block 64'h1E, head 2'b01, with bypass_i=1 -> scr_data_o=64'h1E. The next non-bypass block scrambles from the state held before bypass, matching the bench model.
- encode_error_i=1 on 3 valid cycles and 2 invalid cycles -> err_cnt_o=3. Drive 70000 error cycles -> err_cnt_o=16'hFFFF. Assert clr together with an error -> err_cnt_o=0.
- Assert rst_i=0 mid-stream -> all outputs 0 immediately (asynchronous). After release, first output equals the model computed from SCR_SEED.
- TX_PRBS31_EN with test_mode_i=1 for 100 valid cycles -> 6600-bit stream {data,head} matches a PRBS31 reference checker with zero errors. Deasserting test_mode_i resumes scrambling from the held state.
